// File: rtl/vga_timing_gen.sv
// vga_timing_gen: SVGA 800x600@60 raster timing generator.
// Produces registered horizontal/vertical pixel counters for the RGB fetch
// stage, plus hsync/vsync/video_on/line_start/frame_start decoded from those
// counters and delayed by SYNC_DELAY register stages so they line up with the
// fetch stage's registered colour output.
// Optional feature macro: VGA_TEST_PATTERN_EN adds tp_red/tp_green/tp_blue
// colour-bar outputs (registered, one cycle after the counters).
module vga_timing_gen #(
  parameter int   H_ACTIVE   = 800,
  parameter int   H_FP       = 40,
  parameter int   H_SYNC     = 128,
  parameter int   H_BP       = 88,
  parameter int   V_ACTIVE   = 600,
  parameter int   V_FP       = 1,
  parameter int   V_SYNC     = 4,
  parameter int   V_BP       = 23,
  parameter logic H_POL      = 1'b1,
  parameter logic V_POL      = 1'b1,
  parameter int   SYNC_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [10:0] count_rgb,
  output logic [9:0]  reset_count_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_count
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [1:0]  tp_red,
  output logic [1:0]  tp_green,
  output logic [1:0]  tp_blue
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_MAX    = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Inactive value of the decoded bundle {hsync, vsync, video_on, line_start, frame_start}
  localparam logic [4:0]  IDLE_VEC = {~H_POL, ~V_POL, 3'b000};

  // Counters must fit their ports and the pipeline has at most four stages.
  if (H_TOTAL > 2048 || V_TOTAL > 1024 || SYNC_DELAY > 4 || SYNC_DELAY < 0) begin : g_param_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL/SYNC_DELAY out of range");
  end

  logic [10:0] h_r;
  logic [9:0]  v_r;
  logic [7:0]  frame_count_r;

  logic        hsync_s;
  logic        vsync_s;
  logic        video_s;
  logic        line_start_s;
  logic        frame_start_s;
  logic [4:0]  dec_s;
  logic [4:0]  out_s;

  // Raster counters and completed-frame counter; frozen while enable is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_r           <= 11'd0;
      v_r           <= 10'd0;
      frame_count_r <= 8'd0;
    end else if (enable) begin
      if (h_r == H_MAX) begin
        h_r <= 11'd0;
        if (v_r == V_MAX) begin
          v_r           <= 10'd0;
          frame_count_r <= frame_count_r + 8'd1;
        end else begin
          v_r <= v_r + 10'd1;
        end
      end else begin
        h_r <= h_r + 11'd1;
      end
    end
  end

  // Decode sync, active-region and start markers from the current counters.
  always_comb begin
    hsync_s       = ~H_POL;
    vsync_s       = ~V_POL;
    video_s       = 1'b0;
    line_start_s  = 1'b0;
    frame_start_s = 1'b0;
    if ((h_r >= HS_START) && (h_r <= HS_END)) begin
      hsync_s = H_POL;
    end else begin
      hsync_s = ~H_POL;
    end
    if ((v_r >= VS_START) && (v_r <= VS_END)) begin
      vsync_s = V_POL;
    end else begin
      vsync_s = ~V_POL;
    end
    if ((h_r < H_VIS) && (v_r < V_VIS)) begin
      video_s = 1'b1;
    end else begin
      video_s = 1'b0;
    end
    if (h_r == 11'd0) begin
      line_start_s  = 1'b1;
      frame_start_s = (v_r == 10'd0);
    end else begin
      line_start_s  = 1'b0;
      frame_start_s = 1'b0;
    end
  end

  assign dec_s = {hsync_s, vsync_s, video_s, line_start_s, frame_start_s};

  if (SYNC_DELAY == 0) begin : g_no_delay
    assign out_s = dec_s;
  end else begin : g_delay
    logic [4:0] pipe_r [SYNC_DELAY];

    // Delay line for the decoded bundle; shifts only on enabled edges.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < SYNC_DELAY; i++) begin
          pipe_r[i] <= IDLE_VEC;
        end
      end else if (enable) begin
        pipe_r[0] <= dec_s;
        for (int i = 1; i < SYNC_DELAY; i++) begin
          pipe_r[i] <= pipe_r[i-1];
        end
      end
    end

    assign out_s = pipe_r[SYNC_DELAY-1];
  end

  assign count_rgb       = h_r;
  assign reset_count_rgb = v_r;
  assign frame_count     = frame_count_r;
  assign {hsync, vsync, video_on, line_start, frame_start} = out_s;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_s;

  // Colour-bar index: eight 100-pixel-wide bars across the visible line.
  always_comb begin
    bar_s = 3'(h_r / 11'd100);
  end

  // Registered test-pattern colour, black outside the active region.
  always_ff @(posedge clk) begin
    if (reset) begin
      tp_red   <= 2'b00;
      tp_green <= 2'b00;
      tp_blue  <= 2'b00;
    end else if (enable) begin
      if (video_s) begin
        tp_red   <= {bar_s[2], bar_s[2]};
        tp_green <= {bar_s[1], bar_s[1]};
        tp_blue  <= {bar_s[0], bar_s[0]};
      end else begin
        tp_red   <= 2'b00;
        tp_green <= 2'b00;
        tp_blue  <= 2'b00;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size SVGA instance plus a tiny-raster
// instance (SYNC_DELAY=2) so frame wrap and frame_count wrap are reachable.
// Expected values come from an arithmetic model indexed by the number of
// enabled edges since reset, plus a table of hand-computed checkpoints.
module tb_vga_timing_gen;

  typedef struct {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
    int d;
  } prm_t;

  typedef struct {
    int h; int v; int fc;
    int hs; int vs; int vid; int ls; int fs;
    int tp;
  } exp_t;

  typedef struct {
    bit rst; bit en; int cycles;
    int exp_h; int exp_v; int exp_hs; int exp_vid;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;

  logic [10:0] count_rgb_a, count_rgb_b;
  logic [9:0]  reset_count_rgb_a, reset_count_rgb_b;
  logic        hsync_a, vsync_a, video_on_a, line_start_a, frame_start_a;
  logic        hsync_b, vsync_b, video_on_b, line_start_b, frame_start_b;
  logic [7:0]  frame_count_a, frame_count_b;
`ifdef VGA_TEST_PATTERN_EN
  logic [1:0]  tp_red_a, tp_green_a, tp_blue_a;
  logic [1:0]  tp_red_b, tp_green_b, tp_blue_b;
`endif

  int vectors = 0;
  int miscompares = 0;
  int n = 0;

  prm_t pa = '{800, 40, 128, 88, 600, 1, 4, 23, 1};
  prm_t pb = '{8, 2, 3, 3, 4, 1, 2, 2, 2};

  vga_timing_gen dut_a (
    .clk(clk), .reset(reset), .enable(enable),
    .count_rgb(count_rgb_a), .reset_count_rgb(reset_count_rgb_a),
    .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
    .line_start(line_start_a), .frame_start(frame_start_a),
    .frame_count(frame_count_a)
`ifdef VGA_TEST_PATTERN_EN
    , .tp_red(tp_red_a), .tp_green(tp_green_a), .tp_blue(tp_blue_a)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_DELAY(2)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable),
    .count_rgb(count_rgb_b), .reset_count_rgb(reset_count_rgb_b),
    .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
    .line_start(line_start_b), .frame_start(frame_start_b),
    .frame_count(frame_count_b)
`ifdef VGA_TEST_PATTERN_EN
    , .tp_red(tp_red_b), .tp_green(tp_green_b), .tp_blue(tp_blue_b)
`endif
  );

  always #5 clk = ~clk;

  // Expected outputs after k enabled edges since reset, from the timing rules.
  function automatic exp_t model(input prm_t p, input int k);
    exp_t e;
    int ht, vt, m, hm, vm, b;
    ht = p.ha + p.hfp + p.hs + p.hbp;
    vt = p.va + p.vfp + p.vs + p.vbp;
    e.h  = k % ht;
    e.v  = (k / ht) % vt;
    e.fc = (k / (ht * vt)) % 256;
    m = k - p.d;
    if (m < 0) begin
      e.hs = 0; e.vs = 0; e.vid = 0; e.ls = 0; e.fs = 0;
    end else begin
      hm = m % ht;
      vm = (m / ht) % vt;
      e.hs  = (hm >= p.ha + p.hfp && hm < p.ha + p.hfp + p.hs) ? 1 : 0;
      e.vs  = (vm >= p.va + p.vfp && vm < p.va + p.vfp + p.vs) ? 1 : 0;
      e.vid = (hm < p.ha && vm < p.va) ? 1 : 0;
      e.ls  = (hm == 0) ? 1 : 0;
      e.fs  = (hm == 0 && vm == 0) ? 1 : 0;
    end
    e.tp = 0;
    if (k > 0) begin
      hm = (k - 1) % ht;
      vm = ((k - 1) / ht) % vt;
      if (hm < p.ha && vm < p.va) begin
        b = hm / 100;
        e.tp = (((b >> 2) & 1) * 48) + (((b >> 1) & 1) * 12) + ((b & 1) * 3);
      end
    end
    return e;
  endfunction

  function automatic logic [38:0] pack(input exp_t e);
    return {11'(e.h), 10'(e.v), e.hs[0], e.vs[0], e.vid[0], e.ls[0], e.fs[0], 8'(e.fc)};
  endfunction

  task automatic cmp(input string name, input logic [38:0] act, input logic [38:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s n=%0d got=%h want=%h", name, n, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s n=%0d got=%0d want=%0d", name, n, act, exp);
    end
  endtask

  task automatic check_all();
    exp_t ea, eb;
    ea = model(pa, n);
    eb = model(pb, n);
    cmp("inst_a", {count_rgb_a, reset_count_rgb_a, hsync_a, vsync_a, video_on_a,
                   line_start_a, frame_start_a, frame_count_a}, pack(ea));
    cmp("inst_b", {count_rgb_b, reset_count_rgb_b, hsync_b, vsync_b, video_on_b,
                   line_start_b, frame_start_b, frame_count_b}, pack(eb));
`ifdef VGA_TEST_PATTERN_EN
    check_val("tp_a", int'({tp_red_a, tp_green_a, tp_blue_a}), ea.tp);
    check_val("tp_b", int'({tp_red_b, tp_green_b, tp_blue_b}), eb.tp);
`endif
  endtask

  // One clock: drive inputs, advance the model on the edge, check at negedge.
  task automatic step(input bit r, input bit e);
    reset  = r;
    enable = e;
    @(posedge clk);
    if (r) n = 0;
    else if (e) n++;
    @(negedge clk);
    check_all();
  endtask

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 3,   0,    0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1,   1,    0, 0, 1};
    tbl[2]  = '{1'b0, 1'b1, 1,   2,    0, 0, 1};
    tbl[3]  = '{1'b0, 1'b0, 10,  2,    0, 0, 1};
    tbl[4]  = '{1'b0, 1'b1, 838, 840,  0, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 1,   841,  0, 1, 0};
    tbl[6]  = '{1'b0, 1'b1, 127, 968,  0, 1, 0};
    tbl[7]  = '{1'b0, 1'b1, 1,   969,  0, 0, 0};
    tbl[8]  = '{1'b0, 1'b1, 86,  1055, 0, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 1,   0,    1, 0, 0};
    tbl[10] = '{1'b0, 1'b1, 1,   1,    1, 0, 1};
    tbl[11] = '{1'b1, 1'b0, 1,   0,    0, 0, 0};

    @(negedge clk);
    // Table-driven checkpoints on the full-size instance
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < tbl[i].cycles; c++) step(tbl[i].rst, tbl[i].en);
      check_val("tbl_h",   int'(count_rgb_a),       tbl[i].exp_h);
      check_val("tbl_v",   int'(reset_count_rgb_a), tbl[i].exp_v);
      check_val("tbl_hs",  int'(hsync_a),           tbl[i].exp_hs);
      check_val("tbl_vid", int'(video_on_a),        tbl[i].exp_vid);
    end

    // Line wrap 1055->0 with line 5->6, then line_start seen at count 1 only
    while (n < 6 * 1056 - 1) step(1'b0, 1'b1);
    check_val("wrap_pre_h", int'(count_rgb_a), 1055);
    check_val("wrap_pre_v", int'(reset_count_rgb_a), 5);
    step(1'b0, 1'b1);
    check_val("wrap_h", int'(count_rgb_a), 0);
    check_val("wrap_v", int'(reset_count_rgb_a), 6);
    check_val("ls_at0", int'(line_start_a), 0);
    step(1'b0, 1'b1);
    check_val("ls_at1", int'(line_start_a), 1);
    step(1'b0, 1'b1);
    check_val("ls_at2", int'(line_start_a), 0);

    // Freeze at count 500 for 10 cycles, then resume at 501
    while (count_rgb_a != 11'd500 && n < 7 * 1056) step(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      check_val("frz_h",   int'(count_rgb_a), 500);
      check_val("frz_vid", int'(video_on_a), 1);
      check_val("frz_hs",  int'(hsync_a), 0);
    end
    step(1'b0, 1'b1);
    check_val("resume_h", int'(count_rgb_a), 501);

    // Mid-frame reset at (300,7)
    while (!(count_rgb_a == 11'd300 && reset_count_rgb_a == 10'd7) && n < 9 * 1056) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check_val("rst_all", int'({count_rgb_a, reset_count_rgb_a, hsync_a, vsync_a, video_on_a,
                               line_start_a, frame_start_a, frame_count_a}), 0);
    step(1'b0, 1'b1);
    check_val("restart_h", int'(count_rgb_a), 1);

    // Small raster: frame wrap (15,8)->(0,0), frame_count 0->1, frame_start two cycles later
    step(1'b1, 1'b1);
    while (n < 143) step(1'b0, 1'b1);
    check_val("fw_pre", int'({count_rgb_b, reset_count_rgb_b, frame_count_b}),
              int'({11'd15, 10'd8, 8'd0}));
    step(1'b0, 1'b1);
    check_val("fw_post", int'({count_rgb_b, reset_count_rgb_b, frame_count_b}),
              int'({11'd0, 10'd0, 8'd1}));
    step(1'b0, 1'b1);
    check_val("fs_d1", int'(frame_start_b), 0);
    step(1'b0, 1'b1);
    check_val("fs_d2", int'(frame_start_b), 1);
    step(1'b0, 1'b1);
    check_val("fs_d3", int'(frame_start_b), 0);

    // frame_count wraps 255 -> 0 on the small raster
    while (n < 256 * 144 - 1) step(1'b0, 1'b1);
    check_val("fc_255", int'(frame_count_b), 255);
    step(1'b0, 1'b1);
    check_val("fc_wrap", int'(frame_count_b), 0);

    // Randomized enable with occasional resets, checked against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
SVGA 800x600@60 raster timing generator. Runs on the 40 MHz pixel clock and produces the horizontal/vertical pixel counters (count_rgb, reset_count_rgb) consumed by the RGB pixel fetch stage. Also produces hsync/vsync, video_on and frame/line markers. These are delayed through a pipeline so they line up with the fetch stage's one-cycle registered colour output at the VGA connector.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (clocks)
H_SYNC, 128, hsync width (clocks)
H_BP, 88, horizontal back porch; H_TOTAL = sum = 1056
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vsync width (lines)
V_BP, 23, vertical back porch; V_TOTAL = sum = 628
H_POL, 1, hsync active level
V_POL, 1, vsync active level
SYNC_DELAY, 1, pipeline stages (0..4) on sync/markers relative to counters

Ports:
clk  input  1  pixel clock (40 MHz)
reset  input  1  synchronous, active-high reset
enable  input  1  advance raster when high; freeze everything when low
count_rgb  output  11  horizontal counter 0..H_TOTAL-1, registered
reset_count_rgb  output  10  vertical counter 0..V_TOTAL-1, registered
hsync  output  1  horizontal sync, delayed SYNC_DELAY
vsync  output  1  vertical sync, delayed SYNC_DELAY
video_on  output  1  active-region flag, delayed SYNC_DELAY
line_start  output  1  one-cycle pulse for count_rgb==0, delayed SYNC_DELAY
frame_start  output  1  one-cycle pulse for counters (0,0), delayed SYNC_DELAY
frame_count  output  8  completed-frame counter, wraps 255->0

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high and overrides enable.
- Reset values: count_rgb=0, reset_count_rgb=0, hsync=~H_POL, vsync=~V_POL, video_on=0, line_start=0, frame_start=0, frame_count=0. All delay-pipeline stages hold these inactive values.
- Counting: on each enabled edge count_rgb increments. When count_rgb==H_TOTAL-1 it wraps to 0 and reset_count_rgb increments. When reset_count_rgb==V_TOTAL-1 on that same edge it wraps to 0.
- frame_count increments on the edge where both counters wrap together (1055,627 -> 0,0).
- Decode from the current counter values h,v:
  - hsync active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [840,967].
  - vsync active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [601,604], for the whole of each such line.
  - video_on = (h<H_ACTIVE)&&(v<V_ACTIVE).
  - line_start = (h==0); frame_start = (h==0&&v==0).
- Delay: the decoded signals pass through SYNC_DELAY register stages.
  - Output at cycle t reflects the counters at cycle t-SYNC_DELAY.
  - SYNC_DELAY=0 gives a combinational decode of the registered counters.
  - Default 1 matches the downstream fetch stage's one-cycle colour register.
- enable low: counters, frame_count and all delay stages hold, so outputs are frozen (a pulse in progress stays high). Resumes on the next enabled edge with no skipped state.
- Reset mid-frame: all state returns to the reset values on that edge, and the raster restarts at (0,0) on the next enabled edge.
- Arithmetic: counters are unsigned and never exceed TOTAL-1; comparisons are full-width. An elaboration-time check ($error) fires if H_TOTAL>2048, V_TOTAL>1024 or SYNC_DELAY>4.

Optional Feature:
Macro VGA_TEST_PATTERN_EN.
- Defined:
  - Adds outputs tp_red, tp_green, tp_blue (2 bits each), registered with one-cycle latency from the counters.
  - In the active region, bar index b = count_rgb/100 (0..7) selects the colour: tp_red={b[2],b[2]}, tp_green={b[1],b[1]}, tp_blue={b[0],b[0]}.
  - Outside the active region all three are 0.
  - tp_* obey enable and reset like the other outputs.
- Undefined: these ports and their logic are absent, with no other change.

Test Plan:
- Reset held 3 cycles, then enable=1 -> all outputs at reset values during reset. First enabled edge gives count_rgb=1; counters then count 2,3,... on subsequent edges.
- Run one line with SYNC_DELAY=1 -> hsync=1 (H_POL) first seen in the cycle where count_rgb==841, and last seen where count_rgb==968.
- Line wrap -> count_rgb 1055->0 and reset_count_rgb 5->6 on the same edge. line_start is high for exactly one cycle, in the cycle where count_rgb==1.
- Frame wrap: counters (1055,627) -> (0,0), frame_count 0->1, frame_start pulses once one cycle later. vsync covers lines 601..604 (delayed 1). video_on is 0 for h>=800 or v>=600.
- enable low for 10 cycles at count_rgb=500 -> all outputs constant. Next enabled edge gives count_rgb=501. Reset asserted at (300,200) -> next cycle shows all reset values.
- VGA_TEST_PATTERN_EN defined, counters at (250,10) -> one cycle later tp_red=00, tp_green=11, tp_blue=00. At (799,10) -> 11,11,11. At (800,10) -> 00,00,00.
